mult_div_ctrl: RTL and testbench

MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

---
 rtl/mult_div_ctrl_pkg.sv | 38 +++
 rtl/mult_div_ctrl_if.sv | 16 +
 rtl/md_core.sv | 53 +++++
 rtl/mult_div_ctrl.sv | 96 +++++++++
 tb/tb_mult_div_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/mult_div_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, helpers.
// Optional divider build enabled by defining MDU_DIV_EN.
package mult_div_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } md_state_e;

  // Ops that occupy the unit for multiple cycles (drives hazard stall).
  function automatic logic is_md_op(md_op_e op);
    case (op)
      MD_MULT, MD_MULTU: return 1'b1;
`ifdef MDU_DIV_EN
      MD_DIV, MD_DIVU:   return 1'b1;
`endif
      default:           return 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_op(md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/mult_div_ctrl_if.sv
// E-stage / hazard-unit interface of the multiply/divide unit.
interface mult_div_ctrl_if;
  import mult_div_ctrl_pkg::*;

  logic            Start;
  md_op_e          MDOp;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            Busy;
  logic            Start2;
  logic [XLEN-1:0] HI;
  logic [XLEN-1:0] LO;

  modport master (output Start, MDOp, A, B, input Busy, Start2, HI, LO);
  modport slave  (input Start, MDOp, A, B, output Busy, Start2, HI, LO);
endinterface

// File: rtl/md_core.sv
// Combinational 64-bit multiply and (with MDU_DIV_EN) divide on latched operands.
module md_core
  import mult_div_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            is_signed,
  input  logic            is_div,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            div_zero
);

  logic [2*XLEN-1:0] a_ext;
  logic [2*XLEN-1:0] b_ext;
  logic [2*XLEN-1:0] prod;

  // Sign-extend to 64 bits so one unsigned multiplier serves both signednesses.
  assign a_ext = {{XLEN{is_signed & a[XLEN-1]}}, a};
  assign b_ext = {{XLEN{is_signed & b[XLEN-1]}}, b};
  assign prod  = a_ext * b_ext;

`ifdef MDU_DIV_EN
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] divisor;
  logic [XLEN-1:0] q_mag;
  logic [XLEN-1:0] r_mag;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;

  // Magnitude divide then re-sign: quotient truncates toward zero, remainder follows dividend.
  assign a_neg   = is_signed & a[XLEN-1];
  assign b_neg   = is_signed & b[XLEN-1];
  assign a_mag   = a_neg ? (~a + XLEN'(1)) : a;
  assign b_mag   = b_neg ? (~b + XLEN'(1)) : b;
  assign divisor = (b_mag == '0) ? XLEN'(1) : b_mag;
  assign q_mag   = a_mag / divisor;
  assign r_mag   = a_mag % divisor;
  assign quo     = (a_neg ^ b_neg) ? (~q_mag + XLEN'(1)) : q_mag;
  assign rem     = a_neg ? (~r_mag + XLEN'(1)) : r_mag;

  assign div_zero  = is_div & (b == '0);
  assign {hi, lo}  = is_div ? {rem, quo} : prod;
`else
  // No divider built: any divide request suppresses the result write.
  assign div_zero  = is_div;
  assign {hi, lo}  = prod;
`endif

endmodule

// File: rtl/mult_div_ctrl.sv
// Multi-cycle multiply/divide controller: FSM, latency counter, HI/LO registers.
// Define MDU_DIV_EN to enable the DIV state and divide datapath.
module mult_div_ctrl
  import mult_div_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic               clk,
  input  logic               reset,
  mult_div_ctrl_if.slave     bus
);

  localparam int unsigned MAX_CYC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  md_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            op_signed;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] core_hi;
  logic [XLEN-1:0] core_lo;
  logic            core_zero;

  md_core u_core (
    .a         (op_a),
    .b         (op_b),
    .is_signed (op_signed),
    .is_div    (state == DIV),
    .hi        (core_hi),
    .lo        (core_lo),
    .div_zero  (core_zero)
  );

  assign bus.Start2 = bus.Start & is_md_op(bus.MDOp);
  assign bus.Busy   = (state != IDLE);
  assign bus.HI     = hi_q;
  assign bus.LO     = lo_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_signed <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            case (bus.MDOp)
              MD_MULT, MD_MULTU: begin
                op_a      <= bus.A;
                op_b      <= bus.B;
                op_signed <= is_signed_op(bus.MDOp);
                cnt       <= CNT_W'(MULT_CYC - 1);
                state     <= MUL;
              end
`ifdef MDU_DIV_EN
              MD_DIV, MD_DIVU: begin
                op_a      <= bus.A;
                op_b      <= bus.B;
                op_signed <= is_signed_op(bus.MDOp);
                cnt       <= CNT_W'(DIV_CYC - 1);
                state     <= DIV;
              end
`endif
              MD_MTHI: hi_q <= bus.A;
              MD_MTLO: lo_q <= bus.A;
              default: ;
            endcase
          end
        end
        MUL, DIV: begin
          // Result lands on the edge the counter reaches zero; divide-by-zero keeps HI/LO.
          if (cnt == '0) begin
            if (!core_zero) begin
              hi_q <= core_hi;
              lo_q <= core_lo;
            end
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Scoreboard bench for mult_div_ctrl; directed vectors, divide checks depend on MDU_DIV_EN.
module tb_mult_div_ctrl;
  import mult_div_ctrl_pkg::*;

  localparam int unsigned MULT_CYC = 5;
  localparam int unsigned DIV_CYC  = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_div_ctrl_if bus ();

  mult_div_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    int unsigned busy;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: a Busy falling edge is a completed op; pop and compare latency and HI/LO.
  int unsigned busy_cnt  = 0;
  logic        busy_prev = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt  = 0;
      busy_prev = 1'b0;
    end else if (bus.Busy) begin
      busy_cnt++;
      busy_prev = 1'b1;
    end else if (busy_prev) begin
      exp_t e;
      busy_prev = 1'b0;
      if (sb.size() == 0) begin
        check("unexpected_completion", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_busy_cycles"}, 32'(busy_cnt), 32'(e.busy));
        check({e.tag, "_hi"}, bus.HI, e.hi);
        check({e.tag, "_lo"}, bus.LO, e.lo);
      end
      busy_cnt = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    bus.Start = 1'b1;
    bus.MDOp  = op;
    bus.A     = a;
    bus.B     = b;
  endtask

  task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    drive(op, a, b);
    tick();
    bus.Start = 1'b0;
    bus.MDOp  = MD_NONE;
  endtask

  task automatic expect_op(input string tag, input int unsigned busy,
                           input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.tag = tag; e.busy = busy; e.hi = hi; e.lo = lo;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string tag);
    logic done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!bus.Busy) begin
        done = 1'b1;
        break;
      end
    end
    check({tag, "_idle_timeout"}, 32'(done), 32'd1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Start = 1'b0;
    bus.MDOp  = MD_NONE;
    bus.A     = '0;
    bus.B     = '0;
    reset     = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("reset_busy", 32'(bus.Busy), 32'd0);
    check("reset_hi", bus.HI, 32'h0);
    check("reset_lo", bus.LO, 32'h0);

    // Signed multiply of -2 by 3; operands scrambled after acceptance.
    drive(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    #1 check("mult_start2", 32'(bus.Start2), 32'd1);
    expect_op("mult_neg", MULT_CYC, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    bus.A = 32'h1357_9BDF; bus.B = 32'h2468_ACE0;
    wait_idle("mult_neg");

    expect_op("multu_max", MULT_CYC, 32'hFFFF_FFFE, 32'h0000_0001);
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle("multu_max");

    expect_op("mult_min", MULT_CYC, 32'hFFFF_FFFF, 32'h0000_0000);
    issue(MD_MULT, 32'h8000_0000, 32'd2);
    wait_idle("mult_min");

    issue(MD_MTLO, 32'h0000_1234, 32'h0);
    check("mtlo_lo", bus.LO, 32'h0000_1234);
    check("mtlo_busy", 32'(bus.Busy), 32'd0);
    check("mtlo_hi_kept", bus.HI, 32'hFFFF_FFFF);

    // MTHI and a second multiply arrive while busy; both must be ignored.
    expect_op("mult_busy_mthi", MULT_CYC, 32'h0, 32'd42);
    issue(MD_MULT, 32'd6, 32'd7);
    issue(MD_MTHI, 32'h0000_DEAD, 32'h0);
    check("mthi_busy_hi_kept", bus.HI, 32'hFFFF_FFFF);
    drive(MD_MULTU, 32'd100, 32'd100);
    #1 check("busy_start2", 32'(bus.Start2), 32'd1);
    tick();
    bus.Start = 1'b0; bus.MDOp = MD_NONE;
    wait_idle("mult_busy_mthi");

    drive(MD_NONE, 32'd5, 32'd5);
    #1 check("none_start2", 32'(bus.Start2), 32'd0);
    tick();
    bus.Start = 1'b0;
    check("none_busy", 32'(bus.Busy), 32'd0);
    check("none_lo", bus.LO, 32'd42);

    // Reset three cycles into a multiply aborts it with no later write.
    issue(MD_MULT, 32'h0001_0000, 32'h0001_0000);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 32'(bus.Busy), 32'd0);
    check("abort_hi", bus.HI, 32'h0);
    check("abort_lo", bus.LO, 32'h0);
    repeat (8) tick();
    check("abort_hi_late", bus.HI, 32'h0);
    check("abort_lo_late", bus.LO, 32'h0);

    issue(MD_MTLO, 32'h0000_0099, 32'h0);
    check("mtlo2_lo", bus.LO, 32'h0000_0099);
    drive(MD_MTLO, 32'h0000_0055, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.Start = 1'b0; bus.MDOp = MD_NONE;
    check("reset_prio_lo", bus.LO, 32'h0);

`ifdef MDU_DIV_EN
    expect_op("divu_7_2", DIV_CYC, 32'd1, 32'd3);
    issue(MD_DIVU, 32'd7, 32'd2);
    wait_idle("divu_7_2");

    expect_op("div_m7_2", DIV_CYC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div_m7_2");

    expect_op("div_by_zero", DIV_CYC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(MD_DIV, 32'd5, 32'd0);
    wait_idle("div_by_zero");

    expect_op("div_overflow", DIV_CYC, 32'h0, 32'h8000_0000);
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("div_overflow");
`else
    issue(MD_MTHI, 32'h0000_AAAA, 32'h0);
    issue(MD_MTLO, 32'h0000_5555, 32'h0);
    drive(MD_DIV, 32'd9, 32'd3);
    #1 check("nodiv_start2", 32'(bus.Start2), 32'd0);
    tick();
    bus.Start = 1'b0; bus.MDOp = MD_NONE;
    check("nodiv_busy", 32'(bus.Busy), 32'd0);
    issue(MD_DIVU, 32'd9, 32'd3);
    check("nodivu_busy", 32'(bus.Busy), 32'd0);
    repeat (12) tick();
    check("nodiv_busy_late", 32'(bus.Busy), 32'd0);
    check("nodiv_hi", bus.HI, 32'h0000_AAAA);
    check("nodiv_lo", bus.LO, 32'h0000_5555);
`endif

    repeat (3) tick();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
